// File: rtl/if_id_buffer_if.sv
// ----------------------------------------------------------------------------
// if_id_buffer_if
// Purpose : groups the fetch-side push port, the decode-side pop port, the
//           flush request and the occupancy count of the IF/ID buffer.
// Signals :
//   in_valid/in_pc/in_instr  fetch presents a {pc, instruction} word
//   in_ready                 buffer can accept a push this cycle
//   out_valid/out_pc/
//   out_instr/out_misalign   head entry presented to decode
//   out_ready                decode consumes the head this cycle
//   flush                    discard all buffered words (redirect)
//   count                    current occupancy
// Modports: master = pipeline side (fetch + decode + redirect logic),
//           slave  = the buffer itself.
// ----------------------------------------------------------------------------
interface if_id_buffer_if #(
   parameter int XLEN    = 64,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 2
);
   logic               in_valid;
   logic [XLEN-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic               in_ready;
   logic               out_valid;
   logic [XLEN-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic               out_misalign;
   logic               out_ready;
   logic               flush;
   logic [CNT_W-1:0]   count;

   modport master (
      output in_valid, in_pc, in_instr, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_instr, out_misalign, count
   );

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready, flush,
      output in_ready, out_valid, out_pc, out_instr, out_misalign, count
   );
endinterface

// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
// Purpose : first-word-fall-through FIFO between fetch and decode. Holds
//           {pc, instruction, misalign} words so decode stalls never drop a
//           fetched word; a flush discards everything (wrong-path words).
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous, active-high; empties the buffer
//   bus    if_id_buffer_if.slave (push port, pop port, flush, count)
// Parameters:
//   XLEN, INSTR_W  pc / instruction widths
//   DEPTH          number of entries, power of two, >= 2
//   NOP            instruction presented while empty (addi x0,x0,0)
// ----------------------------------------------------------------------------
module if_id_buffer #(
   parameter int                 XLEN    = 64,
   parameter int                 INSTR_W = 32,
   parameter int                 DEPTH   = 2,
   parameter logic [INSTR_W-1:0] NOP     = 32'h00000013
) (
   input  logic          clk,
   input  logic          reset,
   if_id_buffer_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Pointer / occupancy state. count is kept explicitly because equal
   // pointers mean either empty or full.
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic [DEPTH-1:0] valid_q,  valid_d;

   // Storage
   logic [XLEN-1:0]    pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [DEPTH-1:0]   mis_mem;

   logic push_en;
   logic pop_en;

   // in_ready looks at registered occupancy only, so a full buffer refuses a
   // push even when decode pops in the same cycle.
   assign bus.in_ready  = (count_q != FULL_CNT);
   assign bus.out_valid = (count_q != '0);
   assign bus.count     = count_q;

   // A flush wins over both handshakes; the word accepted on the flush cycle
   // is dropped rather than written.
   assign push_en = bus.in_valid & bus.in_ready & ~bus.flush;
   assign pop_en  = bus.out_valid & bus.out_ready & ~bus.flush;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         valid_d  = '0;
      end else begin
         if (push_en) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            valid_d[wr_ptr_q] = 1'b1;
         end
         if (pop_en) begin
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            valid_d[rd_ptr_q] = 1'b0;
         end
         // Push and pop together leave the occupancy unchanged.
         case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   // NOTE: the data array is not reset; the per-entry valid bits already
   // mask stale contents, so resetting wide storage would only add cost.
   always_ff @(posedge clk) begin
      if (push_en) begin
         pc_mem[wr_ptr_q]    <= bus.in_pc;
         instr_mem[wr_ptr_q] <= bus.in_instr;
         mis_mem[wr_ptr_q]   <= (bus.in_pc[1:0] != 2'b00);
      end
   end

   // Head presentation: fall-through from entry[rd_ptr], NOP bubble when empty.
   always_comb begin
      bus.out_pc       = '0;
      bus.out_instr    = NOP;
      bus.out_misalign = 1'b0;
      if (valid_q[rd_ptr_q]) begin
         bus.out_pc       = pc_mem[rd_ptr_q];
         bus.out_instr    = instr_mem[rd_ptr_q];
         bus.out_misalign = mis_mem[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_if_id_buffer.sv
// ----------------------------------------------------------------------------
// tb_if_id_buffer
// Purpose : self-checking bench for if_id_buffer. A queue model tracks what
//           the buffer must hold; a negedge compare process checks every
//           output against it each cycle, and the directed sequence adds
//           hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_if_id_buffer;

   localparam int XLEN    = 64;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 2;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [INSTR_W-1:0] NOP = 32'h00000013;

   typedef struct {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } word_t;

   logic clk;
   logic reset;

   if_id_buffer_if #(.XLEN(XLEN), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

   if_id_buffer #(.XLEN(XLEN), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction pattern derived from the pc so every word is distinguishable.
   function automatic logic [INSTR_W-1:0] instr_of(input logic [XLEN-1:0] pc);
      return 32'hA000_0000 | pc[31:0];
   endfunction

   // ---------------- behavioural model ----------------
   word_t model_q[$];
   bit    model_ok = 0;

   always @(posedge clk) begin
      bit do_push;
      bit do_pop;
      word_t w;
      if (reset) begin
         model_q.delete();
         model_ok = 1;
      end else if (model_ok) begin
         do_push = bus.in_valid && (model_q.size() < DEPTH);
         do_pop  = bus.out_ready && (model_q.size() > 0);
         if (bus.flush) begin
            model_q.delete();
         end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
               w.pc    = bus.in_pc;
               w.instr = bus.in_instr;
               model_q.push_back(w);
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_ok && !reset) begin
         check("cmp_count", 64'(bus.count), 64'(model_q.size()));
         check("cmp_in_ready", 64'(bus.in_ready), 64'(model_q.size() != DEPTH));
         check("cmp_out_valid", 64'(bus.out_valid), 64'(model_q.size() != 0));
         if (model_q.size() == 0) begin
            check("cmp_out_pc_empty", bus.out_pc, 64'h0);
            check("cmp_out_instr_empty", 64'(bus.out_instr), 64'(NOP));
            check("cmp_misalign_empty", 64'(bus.out_misalign), 64'h0);
         end else begin
            check("cmp_out_pc", bus.out_pc, model_q[0].pc);
            check("cmp_out_instr", 64'(bus.out_instr), 64'(model_q[0].instr));
            check("cmp_misalign", 64'(bus.out_misalign), 64'(model_q[0].pc[1:0] != 2'b00));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic rdy, input logic fl);
      bus.in_valid  = v;
      bus.in_pc     = pc;
      bus.in_instr  = instr_of(pc);
      bus.out_ready = rdy;
      bus.flush     = fl;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 64'h0, 1'b0, 1'b0);

      // 1. reset for two cycles
      step();
      step();
      reset = 1'b0;
      check("rst_out_valid", 64'(bus.out_valid), 64'h0);
      check("rst_out_instr", 64'(bus.out_instr), 64'h0000_0013);
      check("rst_out_pc", bus.out_pc, 64'h0);
      check("rst_in_ready", 64'(bus.in_ready), 64'h1);
      check("rst_count", 64'(bus.count), 64'h0);

      // 2. streaming with decode always ready: one-cycle latency, count <= 1
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'(i * 4), 1'b1, 1'b0);
         step();
         check("stream_pc", bus.out_pc, 64'(i * 4));
         check("stream_count", 64'(bus.count), 64'h1);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      step();
      check("stream_drained", 64'(bus.count), 64'h0);

      // 3. stall until full, push while full is ignored, then drain
      drive(1'b1, 64'h0, 1'b0, 1'b0);
      step();
      drive(1'b1, 64'h4, 1'b0, 1'b0);
      step();
      check("full_count", 64'(bus.count), 64'h2);
      check("full_in_ready", 64'(bus.in_ready), 64'h0);
      drive(1'b1, 64'hC, 1'b1, 1'b0);   // push blocked, pop of 0x0 happens
      step();
      check("full_push_ign_count", 64'(bus.count), 64'h1);
      check("full_push_ign_head", bus.out_pc, 64'h4);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      step();
      check("drain_count", 64'(bus.count), 64'h0);
      check("drain_valid", 64'(bus.out_valid), 64'h0);

      // 4. flush beats push and pop on the same edge
      drive(1'b1, 64'h10, 1'b0, 1'b0);
      step();
      drive(1'b1, 64'h14, 1'b0, 1'b0);
      step();
      check("pre_flush_count", 64'(bus.count), 64'h2);
      drive(1'b1, 64'h40, 1'b1, 1'b1);
      step();
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      check("flush_count", 64'(bus.count), 64'h0);
      check("flush_valid", 64'(bus.out_valid), 64'h0);
      check("flush_instr", 64'(bus.out_instr), 64'(NOP));
      step();
      check("flush_0x40_absent", 64'(bus.out_valid), 64'h0);

      // 5. push/pop pairs across many pointer wraps
      drive(1'b1, 64'h0, 1'b0, 1'b0);
      step();
      for (int i = 1; i < 10; i++) begin
         drive(1'b1, 64'(i * 4), 1'b1, 1'b0);
         step();
         check("wrap_head", bus.out_pc, 64'(i * 4));
         check("wrap_count", 64'(bus.count), 64'h1);
      end
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      step();
      check("wrap_drained", 64'(bus.count), 64'h0);

      // 6. misaligned head, then reset mid-stream
      drive(1'b1, 64'h6, 1'b0, 1'b0);
      step();
      check("misalign_flag", 64'(bus.out_misalign), 64'h1);
      check("misalign_pc", bus.out_pc, 64'h6);
      drive(1'b1, 64'h8, 1'b0, 1'b0);
      step();
      check("mid_count", 64'(bus.count), 64'h2);
      drive(1'b1, 64'hC, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      check("mid_rst_valid", 64'(bus.out_valid), 64'h0);
      check("mid_rst_count", 64'(bus.count), 64'h0);
      check("mid_rst_misalign", 64'(bus.out_misalign), 64'h0);
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
